// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/flag inputs and PC/RAS status outputs of the next-PC unit
interface pc_sequencer_if #(
    parameter int PC_W      = 32,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             imem_busy;
    logic             dmem_busy;
    logic             jump;
    logic             call;
    logic             ret;
    logic [2:0]       branch_op;
    logic             zero;
    logic             negative;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  pc;
    logic             redirect;
    logic [CNT_W-1:0] ras_count;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output imem_busy, dmem_busy, jump, call, ret, branch_op, zero, negative, offset,
        input  pc, redirect, ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  imem_busy, dmem_busy, jump, call, ret, branch_op, zero, negative, offset,
        output pc, redirect, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC unit with conditional branches, CALL/RET return-address stack and stall gating
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BNE = 3'b010;
    localparam logic [2:0] BR_BLT = 3'b011;
    localparam logic [2:0] BR_BGE = 3'b100;

    logic [PC_W-1:0]  pc_q;
    logic             redirect_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] top_ptr;
    logic             ovf_q;
    logic             unf_q;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

    logic             stall;
    logic             taken;
    logic             ras_empty;
    logic             ras_full;
    logic [PC_W-1:0]  seq;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  target;
    logic [PTR_W-1:0] push_ptr;
    logic             ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;

    assign stall     = bus.imem_busy | bus.dmem_busy;
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == FULL_CNT);
    assign seq       = pc_q + PC_W'(4);
    assign off_ext   = PC_W'($signed(bus.offset));
    assign target    = seq + (off_ext << 2);
    assign push_ptr  = top_ptr + 1'b1;

    always_comb begin
        taken = 1'b0;
        case (bus.branch_op)
            BR_BEQ:  taken = bus.zero;
            BR_BNE:  taken = ~bus.zero;
            BR_BLT:  taken = bus.negative;
            BR_BGE:  taken = ~bus.negative;
            default: taken = 1'b0;
        endcase
    end

    // Every RAS write stores the return address seq: a push goes to the slot above top,
    // a simultaneous ret+call on a non-empty stack overwrites the top in place.
    always_comb begin
        ras_wr_en  = 1'b0;
        ras_wr_idx = push_ptr;
        if (!RESET && !stall) begin
            if (bus.ret && bus.call && !ras_empty) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = top_ptr;
            end else if (bus.call) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = push_ptr;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ras_wr_en) begin
            ras_mem[ras_wr_idx] <= seq;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            count_q    <= '0;
            top_ptr    <= PTR_W'(RAS_DEPTH - 1);
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (!stall) begin
            if (bus.ret) begin
                if (!ras_empty) begin
                    pc_q       <= ras_mem[top_ptr];
                    redirect_q <= 1'b1;
                    if (!bus.call) begin
                        top_ptr <= top_ptr - 1'b1;
                        count_q <= count_q - 1'b1;
                    end
                end else begin
                    pc_q       <= seq;
                    redirect_q <= 1'b0;
                    unf_q      <= 1'b1;
                    if (bus.call) begin
                        top_ptr <= push_ptr;
                        count_q <= CNT_W'(1);
                    end
                end
            end else if (bus.call) begin
                pc_q       <= target;
                redirect_q <= 1'b1;
                top_ptr    <= push_ptr;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end else if (bus.jump || taken) begin
                pc_q       <= target;
                redirect_q <= 1'b1;
            end else begin
                pc_q       <= seq;
                redirect_q <= 1'b0;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.redirect  = redirect_q;
    assign bus.ras_count = count_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer (32-bit default and 8-bit PC instances)
module tb_pc_sequencer;
    logic CLK = 1'b0;
    logic RESET;
    logic reset8;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    pc_sequencer_if #(.PC_W(32), .OFF_W(8), .RAS_DEPTH(4)) bus ();
    pc_sequencer_if #(.PC_W(8),  .OFF_W(8), .RAS_DEPTH(4)) bus8 ();

    pc_sequencer #(.PC_W(32), .OFF_W(8), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    pc_sequencer #(.PC_W(8), .OFF_W(8), .RAS_DEPTH(4), .RESET_PC(8'h80)) dut8 (
        .CLK   (CLK),
        .RESET (reset8),
        .bus   (bus8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.imem_busy = 0; bus.dmem_busy = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
        bus.branch_op = 3'b000; bus.zero = 0; bus.negative = 0; bus.offset = 8'h00;
    endtask

    task automatic idle8();
        bus8.imem_busy = 0; bus8.dmem_busy = 0; bus8.jump = 0; bus8.call = 0; bus8.ret = 0;
        bus8.branch_op = 3'b000; bus8.zero = 0; bus8.negative = 0; bus8.offset = 8'h00;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc_e, input logic rd_e,
                             input logic [31:0] cnt_e);
        chk({tag, ".pc"}, bus.pc, pc_e);
        chk({tag, ".redirect"}, {31'b0, bus.redirect}, {31'b0, rd_e});
        chk({tag, ".ras_count"}, {29'b0, bus.ras_count}, cnt_e);
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        idle();
        idle8();
        RESET  = 1;
        reset8 = 1;
        tick();
        tick();
        RESET = 0;
        chk_state("reset", 32'h0, 1'b0, 0);
        chk("reset.ovf", {31'b0, bus.ras_ovf}, 32'h0);
        chk("reset.unf", {31'b0, bus.ras_unf}, 32'h0);

        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_state("seq", 32'(4 * i), 1'b0, 0);
        end

        // 0x0C: jump to 0x10 + 12*4 = 0x40
        bus.jump = 1; bus.offset = 8'd12;
        tick(); idle();
        chk_state("jump40", 32'h40, 1'b1, 0);

        bus.branch_op = 3'b001; bus.zero = 1; bus.offset = 8'hFE;
        tick(); idle();
        chk_state("beq_taken", 32'h3C, 1'b1, 0);
        tick();
        chk_state("seq40", 32'h40, 1'b0, 0);
        bus.branch_op = 3'b001; bus.zero = 0; bus.offset = 8'hFE;
        tick(); idle();
        chk_state("beq_not", 32'h44, 1'b0, 0);
        bus.branch_op = 3'b011; bus.negative = 1; bus.offset = 8'd1;
        tick(); idle();
        chk_state("blt_taken", 32'h4C, 1'b1, 0);
        bus.branch_op = 3'b100; bus.negative = 1; bus.offset = 8'd1;
        tick(); idle();
        chk_state("bge_not", 32'h50, 1'b0, 0);
        bus.branch_op = 3'b010; bus.zero = 0; bus.offset = 8'd2;
        tick(); idle();
        chk_state("bne_taken", 32'h5C, 1'b1, 0);
        bus.branch_op = 3'b101; bus.zero = 1; bus.negative = 1; bus.offset = 8'd5;
        tick(); idle();
        chk_state("br_code5", 32'h60, 1'b0, 0);

        // 0x60: jump to 0x64 - 21*4 = 0x10
        bus.jump = 1; bus.offset = 8'hEB;
        tick(); idle();
        chk_state("jump10", 32'h10, 1'b1, 0);
        bus.call = 1; bus.offset = 8'd4;
        tick(); idle();
        chk_state("call", 32'h24, 1'b1, 1);
        bus.ret = 1;
        tick(); idle();
        chk_state("ret", 32'h14, 1'b1, 0);

        // five nested calls with offset 0: each pushes and jumps to pc+4
        for (int i = 1; i <= 5; i++) begin
            bus.call = 1;
            tick(); idle();
            chk_state("ncall", 32'h14 + 32'(4 * i), 1'b1, (i > 4) ? 4 : i);
            chk("ncall.ovf", {31'b0, bus.ras_ovf}, (i == 5) ? 32'h1 : 32'h0);
        end
        ret_exp = '{32'h28, 32'h24, 32'h20, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            bus.ret = 1;
            tick(); idle();
            chk_state("nret", ret_exp[i], 1'b1, 3 - i);
        end
        bus.ret = 1;
        tick(); idle();
        chk_state("ret_empty", 32'h20, 1'b0, 0);
        chk("ret_empty.unf", {31'b0, bus.ras_unf}, 32'h1);
        chk("ret_empty.ovf", {31'b0, bus.ras_ovf}, 32'h1);

        bus.ret = 1; bus.call = 1; bus.offset = 8'd7;
        tick(); idle();
        chk_state("retcall_empty", 32'h24, 1'b0, 1);
        bus.ret = 1; bus.call = 1; bus.offset = 8'd7;
        tick(); idle();
        chk_state("retcall", 32'h24, 1'b1, 1);
        bus.ret = 1;
        tick(); idle();
        chk_state("retcall_pop", 32'h28, 1'b1, 0);

        // imem stall with jump held: target = 0x2C + 12 = 0x38, taken exactly once
        bus.imem_busy = 1; bus.jump = 1; bus.offset = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("imem_hold", 32'h28, 1'b1, 0);
        end
        bus.imem_busy = 0;
        tick(); idle();
        chk_state("imem_rel", 32'h38, 1'b1, 0);
        tick();
        chk_state("after_rel", 32'h3C, 1'b0, 0);
        bus.dmem_busy = 1; bus.call = 1; bus.offset = 8'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_state("dmem_hold", 32'h3C, 1'b0, 0);
        end
        bus.dmem_busy = 0;
        tick(); idle();
        chk_state("dmem_rel", 32'h44, 1'b1, 1);

        bus.imem_busy = 1; bus.call = 1; RESET = 1;
        tick(); idle(); RESET = 0;
        chk_state("reset_stall", 32'h0, 1'b0, 0);
        chk("reset_stall.ovf", {31'b0, bus.ras_ovf}, 32'h0);
        chk("reset_stall.unf", {31'b0, bus.ras_unf}, 32'h0);
        bus.ret = 1;
        tick(); idle();
        chk("reset_ras_empty.pc", bus.pc, 32'h4);
        chk("reset_ras_empty.unf", {31'b0, bus.ras_unf}, 32'h1);

        reset8 = 0;
        chk("w8.reset", {24'b0, bus8.pc}, 32'h80);
        // 0x80: jump to 0x84 + 30*4 = 0xFC
        bus8.jump = 1; bus8.offset = 8'h1E;
        tick(); idle8();
        chk("w8.jump", {24'b0, bus8.pc}, 32'hFC);
        tick();
        chk("w8.wrap", {24'b0, bus8.pc}, 32'h00);
        bus8.jump = 1; bus8.offset = 8'hFE;
        tick(); idle8();
        chk("w8.negwrap", {24'b0, bus8.pc}, 32'hFC);
        bus8.imem_busy = 1;
        tick();
        chk("w8.stall", {24'b0, bus8.pc}, 32'hFC);
        reset8 = 1;
        tick();
        chk("w8.reset_stall", {24'b0, bus8.pc}, 32'h80);
        reset8 = 0; idle8();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
